// File: rtl/vga_timing_gen.sv
// VGA raster timing: h/v counters, frame-buffer coordinates at half resolution,
// active/blank flags and delayed active-low syncs.
module vga_timing_gen #(
    parameter int H_ACTIVE   = 640,
    parameter int H_FP       = 16,
    parameter int H_SYNC     = 96,
    parameter int H_BP       = 48,
    parameter int V_ACTIVE   = 480,
    parameter int V_FP       = 10,
    parameter int V_SYNC     = 2,
    parameter int V_BP       = 33,
    parameter int SYNC_DELAY = 2
) (
    input  logic       clock,
    input  logic       reset,
    output logic [8:0] x,
    output logic [8:0] y,
    output logic       in_active_area,
    output logic       hsync,
    output logic       vsync,
    output logic       vblank,
    output logic       frame_start
);

    localparam logic [9:0] H_ACT  = 10'(H_ACTIVE);
    localparam logic [9:0] H_LAST = 10'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
    localparam logic [9:0] HS_BEG = 10'(H_ACTIVE + H_FP);
    localparam logic [9:0] HS_END = 10'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [9:0] V_ACT  = 10'(V_ACTIVE);
    localparam logic [9:0] V_LAST = 10'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);
    localparam logic [9:0] VS_BEG = 10'(V_ACTIVE + V_FP);
    localparam logic [9:0] VS_END = 10'(V_ACTIVE + V_FP + V_SYNC);

    logic [9:0] h_count;
    logic [9:0] v_count;
    logic       reset_q;
    logic       hold;
    logic       h_act;
    logic       v_act;
    logic [8:0] v_next_row;
    logic       hs_raw;
    logic       vs_raw;

    logic [SYNC_DELAY:0] hs_pipe;
    logic [SYNC_DELAY:0] vs_pipe;

    // Counters stay parked one extra clock after reset so the first
    // active pixel appears two clocks after release.
    always_ff @(posedge clock) begin
        reset_q <= reset;
    end

    assign hold = reset | reset_q;

    always_ff @(posedge clock) begin
        if (hold) begin
            h_count <= '0;
            v_count <= '0;
        end else if (h_count == H_LAST) begin
            h_count <= '0;
            if (v_count == V_LAST) begin
                v_count <= '0;
            end else begin
                v_count <= v_count + 10'd1;
            end
        end else begin
            h_count <= h_count + 10'd1;
        end
    end

    always_comb begin
        h_act  = (h_count < H_ACT);
        v_act  = (v_count < V_ACT);
        hs_raw = !((h_count >= HS_BEG) && (h_count < HS_END));
        vs_raw = !((v_count >= VS_BEG) && (v_count < VS_END));
        if (v_count == V_LAST) begin
            v_next_row = '0;
        end else begin
            v_next_row = 9'((v_count + 10'd1) >> 1);
        end
    end

    always_ff @(posedge clock) begin
        if (hold) begin
            x              <= '0;
            y              <= '0;
            in_active_area <= 1'b0;
            vblank         <= 1'b0;
            frame_start    <= 1'b0;
        end else begin
            x              <= h_act ? h_count[9:1] : '0;
            y              <= h_act ? v_count[9:1] : v_next_row;
            in_active_area <= h_act && v_act;
            vblank         <= !v_act;
            frame_start    <= (h_count == '0) && (v_count == '0);
        end
    end

    // Stage 0 is the output register; stages 1..SYNC_DELAY add the delay.
    always_ff @(posedge clock) begin
        if (hold) begin
            hs_pipe <= '1;
            vs_pipe <= '1;
        end else begin
            for (int i = SYNC_DELAY; i > 0; i--) begin
                hs_pipe[i] <= hs_pipe[i-1];
                vs_pipe[i] <= vs_pipe[i-1];
            end
            hs_pipe[0] <= hs_raw;
            vs_pipe[0] <= vs_raw;
        end
    end

    assign hsync = hs_pipe[SYNC_DELAY];
    assign vsync = vs_pipe[SYNC_DELAY];

endmodule

// File: tb/tb_vga_timing_gen.sv
// Randomized-reset bench: a time-indexed raster model feeds a scoreboard
// queue that a monitor drains one entry per clock.
module tb_vga_timing_gen;

    localparam int HA = 16;
    localparam int HF = 4;
    localparam int HS = 6;
    localparam int HB = 6;
    localparam int VA = 12;
    localparam int VF = 2;
    localparam int VS = 2;
    localparam int VB = 3;
    localparam int SD = 3;
    localparam int HT = HA + HF + HS + HB;
    localparam int VT = VA + VF + VS + VB;
    localparam int NCYC = 30000;

    typedef struct packed {
        logic [8:0] x;
        logic [8:0] y;
        logic       act;
        logic       hs;
        logic       vs;
        logic       vb;
        logic       fs;
    } out_t;

    logic       clock;
    logic       reset;
    logic [8:0] x;
    logic [8:0] y;
    logic       in_active_area;
    logic       hsync;
    logic       vsync;
    logic       vblank;
    logic       frame_start;

    out_t exp_q[$];
    logic [1:0] sync_q[$];
    int   total;
    int   bad;
    bit   started;
    bit   done;

    vga_timing_gen #(
        .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
        .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
        .SYNC_DELAY(SD)
    ) dut (
        .clock(clock),
        .reset(reset),
        .x(x),
        .y(y),
        .in_active_area(in_active_area),
        .hsync(hsync),
        .vsync(vsync),
        .vblank(vblank),
        .frame_start(frame_start)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Output after one clock edge: t counts clocks since the raster was
    // launched, so (h, v) follow directly from division.
    function automatic out_t raster(input int t);
        int h;
        int v;
        int vn;
        out_t e;
        h  = t % HT;
        v  = (t / HT) % VT;
        vn = (v + 1) % VT;
        e.x   = (h < HA) ? 9'(h / 2) : 9'd0;
        e.y   = (h < HA) ? 9'(v / 2) : 9'(vn / 2);
        e.act = (h < HA) && (v < VA);
        e.hs  = !((h >= HA + HF) && (h < HA + HF + HS));
        e.vs  = !((v >= VA + VF) && (v < VA + VF + VS));
        e.vb  = (v >= VA);
        e.fs  = (h == 0) && (v == 0);
        return e;
    endfunction

    // Stimulus and model.
    initial begin
        int   t;
        int   burst;
        bit   r;
        bit   prev_r;
        out_t e;
        logic [1:0] s;
        total   = 0;
        bad     = 0;
        started = 1'b0;
        done    = 1'b0;
        reset   = 1'b1;
        t       = 0;
        burst   = 0;
        prev_r  = 1'b1;
        for (int c = 0; c < NCYC; c++) begin
            @(negedge clock);
            if (c < 5) begin
                r = 1'b1;
            end else if (c == 1000) begin
                r = 1'b1;
                burst = 4;
            end else if (burst > 0) begin
                r = 1'b1;
                burst--;
            end else if ($urandom_range(0, 2999) == 0) begin
                r = 1'b1;
                burst = int'($urandom_range(0, 5));
            end else begin
                r = 1'b0;
            end
            reset = r;
            if (r || prev_r) begin
                e = '{x: 9'd0, y: 9'd0, act: 1'b0, hs: 1'b1,
                      vs: 1'b1, vb: 1'b0, fs: 1'b0};
                t = 0;
                sync_q.delete();
                for (int i = 0; i < SD; i++) sync_q.push_back(2'b11);
            end else begin
                e = raster(t);
                sync_q.push_back({e.hs, e.vs});
                s = sync_q.pop_front();
                e.hs = s[1];
                e.vs = s[0];
                t++;
            end
            prev_r = r;
            exp_q.push_back(e);
            started = 1'b1;
        end
        @(posedge clock);
        #3;
        done = 1'b1;
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL drain: left=%0d required=0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Monitor: the DUT presents a new output every clock.
    initial begin
        out_t e;
        out_t a;
        forever begin
            @(posedge clock);
            #1;
            if (started && !done) begin
                total++;
                if (exp_q.size() == 0) begin
                    bad++;
                    $display("FAIL underflow: no expected entry at %0t", $time);
                end else begin
                    e = exp_q.pop_front();
                    a = '{x: x, y: y, act: in_active_area, hs: hsync,
                          vs: vsync, vb: vblank, fs: frame_start};
                    if (a !== e) begin
                        bad++;
                        $display("FAIL outputs @%0t: got x=%0d y=%0d a=%b h=%b v=%b vb=%b fs=%b required x=%0d y=%0d a=%b h=%b v=%b vb=%b fs=%b",
                                 $time, a.x, a.y, a.act, a.hs, a.vs, a.vb, a.fs,
                                 e.x, e.y, e.act, e.hs, e.vs, e.vb, e.fs);
                    end
                end
            end
        end
    end

endmodule
